wb_stage_mc: RTL and testbench
==============================

Name: wb_stage_mc

Overview:
- Multi-lane, parametrised writeback stage at the tail of the pipeline.
- Accepts one bundle of NLANES instructions per cycle, in program order with lane 0 the oldest.
- Resolves each lane's branch condition from its flags and kills lanes younger than the first taken branch.
- Discards whole bundles from the wrong path using a 1-bit epoch, and registers results to the register file and fetch behind a 2-entry skid buffer with a valid/ready handshake.
- Also keeps a count of retired instructions.

Parameters:
- XLEN, 32, data and PC width.
- NLANES, 2, lanes per bundle (1..4).
- REG_W, 5, register index width.
- CNT_W, 32, retire-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_valid  in  1  input bundle valid.
- i_ready  out  1  stage can accept a bundle.
- i_epoch  in  1  epoch tag of the input bundle.
- i_lane_valid  in  NLANES  per-lane instruction present.
- i_cond  in  3*NLANES  per-lane cond_t.
- i_zero  in  NLANES  per-lane zero flag.
- i_carry  in  NLANES  per-lane carry flag.
- i_branch  in  XLEN*NLANES  per-lane branch target.
- i_wback  in  NLANES  per-lane register-write enable.
- i_wreg  in  REG_W*NLANES  per-lane destination register.
- i_wdata  in  XLEN*NLANES  per-lane write data.
- o_valid  out  1  output bundle valid.
- o_ready  in  1  consumer accepts the output bundle.
- o_wback  out  NLANES  qualified write enables.
- o_wreg  out  REG_W*NLANES  destination registers.
- o_wdata  out  XLEN*NLANES  write data.
- o_pcsel  out  1  redirect fetch.
- o_pc  out  XLEN  redirect target.
- o_epoch  out  1  current epoch; fetch tags new bundles with it.
- o_retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst=0, asynchronous):
  - o_valid=0, o_wback=0, o_wreg=0, o_wdata=0, o_pcsel=0, o_pc=0.
  - epoch=0, skid empty, o_retired=0.
  - i_ready=0 while reset is held, then 1 on the first cycle after release.
  - Any in-flight or skid bundle is dropped.
- Condition decode per lane (cond_t):
  - Never: not taken.
  - Zero: taken when zero=1.
  - NotZero: taken when zero=0.
  - Carry: taken when carry=1.
  - NotCarry: taken when carry=0.
  - Always: taken.
  - Unlisted codes: not taken.
- Acceptance: a bundle is accepted when i_valid && i_ready.
  - A bundle with i_epoch != epoch is stale: consumed with no effect. No output, no counter change, no redirect.
- Lane kill (current-epoch bundle):
  - Lane k is live iff i_lane_valid[k] and no lane j<k is valid and taken.
  - t is the lowest live taken lane.
  - If t exists: pcsel=1, pc=i_branch[t], and epoch toggles at the accept edge. The next accepted bundle is compared against the new epoch.
- Write qualification: wback[k] = live[k] && i_wback[k] && i_wreg[k]!=0. Writes to r0 are suppressed. wreg and wdata pass through unchanged.
- Latency: exactly 1 cycle from acceptance to o_valid, when the output register is free or draining.
- Skid buffer (2 entries: output register + skid):
  - i_ready = skid empty.
  - Accept while output is held (o_valid && !o_ready): bundle goes to skid, and i_ready drops to 0 the next cycle.
  - On output transfer, skid moves to output and i_ready rises the next cycle.
  - Output contents are stable while o_valid && !o_ready.
- Retire counter: on each output transfer (o_valid && o_ready), o_retired increases by popcount(live) of that bundle. It wraps modulo 2^CNT_W.
- o_pcsel: asserted only while its bundle is at the output; one pulse per transfer.
- Simultaneous transfer-out and accept: both happen in the same cycle; no bubble, no loss.
- A bundle with all lanes invalid still produces an output beat with o_wback=0.

Decomposition:
- Shared package Common:
  - cond_t (Never, Zero, NotZero, Carry, NotCarry, Always), 3 bits.
  - Packed wb_lane_t {cond, zero, carry, branch, wback, wreg, wdata}.
  - wb_bundle_t {lanes, pcsel, pc}.
  - Helper function cond_taken(cond, zero, carry).
- One natural sub-module: wb_skid_buf, a generic 2-entry valid/ready skid register parametrised on payload width.

Test Plan:
- Reset mid-stream: skid full and o_valid=1, pulse rst low → all outputs 0, o_retired=0, o_epoch=0 immediately, with no clock edge needed.
- NLANES=2, epoch 0, lane0 cond=Zero zero=1 branch=0x100, lane1 wback=1 wreg=3 → next cycle o_pcsel=1, o_pc=0x100, o_wback=2'b00, o_epoch=1, o_retired+=1.
- After the redirect above, bundle with i_epoch=0 accepted → no o_valid, o_retired unchanged. Then a bundle with i_epoch=1 → normal output.
- Both lanes wback=1, wreg={0,7}, cond=Never → o_wback=2'b10, o_pcsel=0, o_retired+=2.
- Hold o_ready=0 and send 3 bundles → first two held, i_ready=0 after the second. Raise o_ready → bundles emerge in order, no loss or duplication, o_retired correct.
- o_retired=2^CNT_W-1 and a bundle with 2 live lanes transfers → o_retired=1.

Source files
------------

// File: rtl/wb_stage_mc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : wb_stage_mc_pkg
// Brief  : Shared types and branch-condition helper for the writeback stage.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package wb_stage_mc_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_W_DEF  = 5;
    localparam int NLANES_DEF = 2;

    typedef enum logic [2:0] {
        COND_NEVER    = 3'd0,
        COND_ZERO     = 3'd1,
        COND_NOTZERO  = 3'd2,
        COND_CARRY    = 3'd3,
        COND_NOTCARRY = 3'd4,
        COND_ALWAYS   = 3'd5
    } cond_t;

    // Canonical lane/bundle layout at the default widths.
    typedef struct packed {
        cond_t                  cond;
        logic                   zero;
        logic                   carry;
        logic [XLEN_DEF-1:0]    branch;
        logic                   wback;
        logic [REG_W_DEF-1:0]   wreg;
        logic [XLEN_DEF-1:0]    wdata;
    } wb_lane_t;

    typedef struct packed {
        wb_lane_t [NLANES_DEF-1:0] lanes;
        logic                      pcsel;
        logic [XLEN_DEF-1:0]       pc;
    } wb_bundle_t;

    function automatic logic cond_taken(input logic [2:0] cond,
                                        input logic       zero,
                                        input logic       carry);
        logic r;
        case (cond)
            COND_ZERO:     r = zero;
            COND_NOTZERO:  r = ~zero;
            COND_CARRY:    r = carry;
            COND_NOTCARRY: r = ~carry;
            COND_ALWAYS:   r = 1'b1;
            default:       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_stage_mc_skid_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : wb_skid_buf
// Brief  : Generic 2-entry valid/ready register (output register + skid).
// Rev    : 1.0
// ---------------------------------------------------------------------------
module wb_skid_buf
    import wb_stage_mc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_data
);

    logic         out_valid_q, out_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         w_accept;

    assign o_in_ready = ~skid_valid_q;
    assign w_accept   = i_valid & ~skid_valid_q;
    assign o_valid    = out_valid_q;
    assign o_data     = out_data_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || i_out_ready) begin
            // Output register free or draining: the skid entry is older than any new input.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = w_accept;
                if (w_accept) begin
                    out_data_d = i_data;
                end
            end
        end else if (w_accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_data_q   <= '0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_data_q   <= out_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_stage_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : wb_stage_mc
// Brief  : Multi-lane writeback stage with branch kill, epoch filter and skid.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module wb_stage_mc
    import wb_stage_mc_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NLANES = 2,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic                    i_epoch,
    input  logic [NLANES-1:0]       i_lane_valid,
    input  logic [3*NLANES-1:0]     i_cond,
    input  logic [NLANES-1:0]       i_zero,
    input  logic [NLANES-1:0]       i_carry,
    input  logic [XLEN*NLANES-1:0]  i_branch,
    input  logic [NLANES-1:0]       i_wback,
    input  logic [REG_W*NLANES-1:0] i_wreg,
    input  logic [XLEN*NLANES-1:0]  i_wdata,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [NLANES-1:0]       o_wback,
    output logic [REG_W*NLANES-1:0] o_wreg,
    output logic [XLEN*NLANES-1:0]  o_wdata,
    output logic                    o_pcsel,
    output logic [XLEN-1:0]         o_pc,
    output logic                    o_epoch,
    output logic [CNT_W-1:0]        o_retired
);

    localparam int CW = $clog2(NLANES + 1);
    localparam int PW = 1 + XLEN + NLANES + REG_W*NLANES + XLEN*NLANES + CW;

    logic             epoch_q, epoch_d;
    logic             init_q, init_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic [NLANES-1:0] w_wback;
    logic              w_redirect;
    logic [XLEN-1:0]   w_pc;
    logic [CW-1:0]     w_cnt;
    logic              w_kill;
    logic              w_fresh;
    logic              w_skid_ready;
    logic              w_out_valid;
    logic [PW-1:0]     w_in_data;
    logic [PW-1:0]     w_out_data;
    logic [CW-1:0]     w_out_cnt;

    // Lanes are in program order, so the first valid taken lane kills everything after it.
    always_comb begin
        w_kill     = 1'b0;
        w_redirect = 1'b0;
        w_pc       = '0;
        w_wback    = '0;
        w_cnt      = '0;
        for (int k = 0; k < NLANES; k++) begin
            if (i_lane_valid[k] && !w_kill) begin
                w_cnt = w_cnt + CW'(1);
                if (i_wback[k] && (i_wreg[k*REG_W +: REG_W] != '0)) begin
                    w_wback[k] = 1'b1;
                end
                if (cond_taken(i_cond[3*k +: 3], i_zero[k], i_carry[k])) begin
                    w_kill     = 1'b1;
                    w_redirect = 1'b1;
                    w_pc       = i_branch[k*XLEN +: XLEN];
                end
            end
        end
    end

    assign i_ready   = init_q & w_skid_ready;
    assign w_fresh   = i_valid & i_ready & (i_epoch == epoch_q);
    assign w_in_data = {w_redirect, w_pc, w_wback, i_wreg, i_wdata, w_cnt};

    wb_skid_buf #(
        .W (PW)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst),
        .i_valid     (w_fresh),
        .o_in_ready  (w_skid_ready),
        .i_data      (w_in_data),
        .o_valid     (w_out_valid),
        .i_out_ready (o_ready),
        .o_data      (w_out_data)
    );

    assign {o_pcsel, o_pc, o_wback, o_wreg, o_wdata, w_out_cnt} = w_out_data;
    assign o_valid   = w_out_valid;
    assign o_epoch   = epoch_q;
    assign o_retired = retired_q;

    always_comb begin
        init_d    = 1'b1;
        epoch_d   = epoch_q ^ (w_fresh & w_redirect);
        retired_d = retired_q;
        if (w_out_valid && o_ready) begin
            retired_d = retired_q + CNT_W'(w_out_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_q    <= 1'b0;
            epoch_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            init_q    <= init_d;
            epoch_q   <= epoch_d;
            retired_q <= retired_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_wb_stage_mc
// Brief  : Vector table plus scoreboard bench for wb_stage_mc (NLANES=2).
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_wb_stage_mc;
    import wb_stage_mc_pkg::*;

    localparam int XLEN = 32, NLANES = 2, REG_W = 5, CNT_W = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        i_valid = 1'b0, i_ready, i_epoch = 1'b0;
    logic [1:0]  i_lane_valid = '0, i_zero = '0, i_carry = '0, i_wback = '0;
    logic [5:0]  i_cond = '0;
    logic [63:0] i_branch = '0, i_wdata = '0;
    logic [9:0]  i_wreg = '0;
    logic        o_valid, o_ready = 1'b1, o_pcsel, o_epoch;
    logic [1:0]  o_wback;
    logic [9:0]  o_wreg;
    logic [63:0] o_wdata;
    logic [31:0] o_pc;
    logic [CNT_W-1:0] o_retired;

    wb_stage_mc #(.XLEN(XLEN), .NLANES(NLANES), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_epoch(i_epoch),
        .i_lane_valid(i_lane_valid), .i_cond(i_cond), .i_zero(i_zero), .i_carry(i_carry),
        .i_branch(i_branch), .i_wback(i_wback), .i_wreg(i_wreg), .i_wdata(i_wdata),
        .o_valid(o_valid), .o_ready(o_ready), .o_wback(o_wback), .o_wreg(o_wreg),
        .o_wdata(o_wdata), .o_pcsel(o_pcsel), .o_pc(o_pc), .o_epoch(o_epoch),
        .o_retired(o_retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ep; logic [1:0] lv; logic [5:0] cond; logic [1:0] z, c;
        logic [63:0] br; logic [1:0] wb; logic [9:0] wreg;
        logic stale; logic [1:0] ewb; logic epc; logic [31:0] epcv; int ecnt; logic eep;
    } vec_t;

    typedef struct {
        logic [1:0] wb; logic [9:0] wreg; logic [63:0] wdata;
        logic pcsel; logic [31:0] pc; int cnt;
    } exp_t;

    exp_t             q[$];
    int               n_vec = 0, n_fail = 0;
    logic [CNT_W-1:0] exp_ret = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ep, input logic [1:0] lv,
                                input logic [2:0] c1, input logic [2:0] c0,
                                input logic [1:0] z, input logic [1:0] c,
                                input logic [31:0] b1, input logic [31:0] b0,
                                input logic [1:0] wb, input logic [4:0] r1, input logic [4:0] r0,
                                input logic stale, input logic [1:0] ewb, input logic epc,
                                input logic [31:0] epcv, input int ecnt, input logic eep);
        vec_t v;
        v.ep = ep; v.lv = lv; v.cond = {c1, c0}; v.z = z; v.c = c;
        v.br = {b1, b0}; v.wb = wb; v.wreg = {r1, r0};
        v.stale = stale; v.ewb = ewb; v.epc = epc; v.epcv = epcv; v.ecnt = ecnt; v.eep = eep;
        return v;
    endfunction

    task automatic send(input vec_t v);
        exp_t e;
        int   n;
        i_epoch = v.ep; i_lane_valid = v.lv; i_cond = v.cond; i_zero = v.z; i_carry = v.c;
        i_branch = v.br; i_wback = v.wb; i_wreg = v.wreg;
        i_wdata = {$urandom(), $urandom()};
        i_valid = 1'b1;
        n = 0;
        while (!i_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (!i_ready) begin
            n_vec++; n_fail++;
            $display("FAIL accept_timeout: got i_ready=0 expected 1");
            i_valid = 1'b0;
            return;
        end
        e.wb = v.ewb; e.wreg = v.wreg; e.wdata = i_wdata;
        e.pcsel = v.epc; e.pc = v.epcv; e.cnt = v.ecnt;
        if (!v.stale) q.push_back(e);
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("epoch", o_epoch, v.eep);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 30) begin
            @(posedge clk); n++;
        end
        #1;
        chk("drain", q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && o_valid && o_ready) begin
            if (q.size() == 0) begin
                n_vec++; n_fail++;
                $display("FAIL unexpected_beat: got o_valid=1 expected no output");
            end else begin
                e = q.pop_front();
                chk("o_wback", o_wback, e.wb);
                chk("o_wreg", o_wreg, e.wreg);
                chk("o_wdata", o_wdata, e.wdata);
                chk("o_pcsel", o_pcsel, e.pcsel);
                if (e.pcsel) chk("o_pc", o_pc, e.pc);
                chk("o_retired", o_retired, exp_ret);
                exp_ret = exp_ret + CNT_W'(e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl[10];
        vec_t nb, wr;

        #1 rst = 1'b0;
        #3;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_i_ready", i_ready, 0);
        chk("rst_o_retired", o_retired, 0);
        chk("rst_o_epoch", o_epoch, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", i_ready, 1);

        tbl[0] = mk(0, 2'b11, COND_NEVER, COND_ZERO, 2'b01, 2'b00, 32'h555, 32'h100, 2'b10, 5'd3, 5'd0, 0, 2'b00, 1, 32'h100, 1, 1);
        tbl[1] = mk(0, 2'b11, COND_NEVER, COND_NEVER, 2'b00, 2'b00, 0, 0, 2'b11, 5'd1, 5'd2, 1, 2'b00, 0, 0, 0, 1);
        tbl[2] = mk(1, 2'b11, COND_NEVER, COND_NEVER, 2'b00, 2'b00, 0, 0, 2'b11, 5'd7, 5'd0, 0, 2'b10, 0, 0, 2, 1);
        tbl[3] = mk(1, 2'b11, COND_CARRY, COND_NOTZERO, 2'b01, 2'b10, 32'h2000, 32'h1111, 2'b11, 5'd5, 5'd4, 0, 2'b11, 1, 32'h2000, 2, 0);
        tbl[4] = mk(0, 2'b10, COND_ALWAYS, COND_ALWAYS, 2'b00, 2'b00, 32'h44, 32'h999, 2'b11, 5'd9, 5'd8, 0, 2'b10, 1, 32'h44, 1, 1);
        tbl[5] = mk(1, 2'b00, COND_ALWAYS, COND_ALWAYS, 2'b00, 2'b00, 32'h12, 32'h34, 2'b11, 5'd1, 5'd1, 0, 2'b00, 0, 0, 0, 1);
        tbl[6] = mk(1, 2'b11, COND_ZERO, COND_NOTCARRY, 2'b10, 2'b00, 32'h66, 32'h80, 2'b11, 5'd3, 5'd2, 0, 2'b01, 1, 32'h80, 1, 0);
        tbl[7] = mk(0, 2'b11, 3'd7, 3'd6, 2'b11, 2'b11, 32'h1, 32'h2, 2'b11, 5'd31, 5'd1, 0, 2'b11, 0, 0, 2, 0);
        tbl[8] = mk(0, 2'b11, COND_ALWAYS, COND_NOTZERO, 2'b00, 2'b00, 32'h77, 32'h300, 2'b01, 5'd5, 5'd6, 0, 2'b01, 1, 32'h300, 1, 1);
        tbl[9] = mk(0, 2'b11, COND_ALWAYS, COND_ALWAYS, 2'b00, 2'b00, 32'h9, 32'h8, 2'b11, 5'd2, 5'd3, 1, 2'b00, 0, 0, 0, 1);

        for (int i = 0; i < 10; i++) begin
            send(tbl[i]);
            if (tbl[i].stale) chk("stale_no_output", o_valid, 0);
        end
        drain();

        // Backpressure: two bundles fill output+skid, third waits for o_ready.
        nb = mk(1, 2'b11, COND_NEVER, COND_NEVER, 2'b00, 2'b00, 0, 0, 2'b11, 5'd10, 5'd11, 0, 2'b11, 0, 0, 2, 1);
        o_ready = 1'b0;
        fork
            begin
                send(nb);
                send(nb);
                chk("skid_full_ready", i_ready, 0);
                chk("skid_full_valid", o_valid, 1);
                send(nb);
            end
            begin
                repeat (8) @(posedge clk);
                #3 o_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset with skid full and pending redirects.
        o_ready = 1'b0;
        send(mk(1, 2'b01, COND_NEVER, COND_ALWAYS, 2'b00, 2'b00, 0, 32'hA0, 2'b01, 5'd1, 5'd4, 0, 2'b01, 1, 32'hA0, 1, 0));
        send(mk(0, 2'b01, COND_NEVER, COND_ALWAYS, 2'b00, 2'b00, 0, 32'hB0, 2'b01, 5'd1, 5'd5, 0, 2'b01, 1, 32'hB0, 1, 1));
        chk("pre_rst_valid", o_valid, 1);
        chk("pre_rst_ready", i_ready, 0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_o_valid", o_valid, 0);
        chk("mid_rst_o_wback", o_wback, 0);
        chk("mid_rst_o_wreg", o_wreg, 0);
        chk("mid_rst_o_wdata", o_wdata, 0);
        chk("mid_rst_o_pcsel", o_pcsel, 0);
        chk("mid_rst_o_pc", o_pc, 0);
        chk("mid_rst_o_retired", o_retired, 0);
        chk("mid_rst_o_epoch", o_epoch, 0);
        chk("mid_rst_i_ready", i_ready, 0);
        q.delete();
        exp_ret = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        o_ready = 1'b1;
        chk("post_rst_ready_low", i_ready, 0);
        @(posedge clk); #1;
        chk("post_rst_ready_high", i_ready, 1);

        // Counter wrap: reach 2^CNT_W-1 then retire two more.
        wr = mk(0, 2'b11, COND_NEVER, COND_NEVER, 2'b00, 2'b00, 0, 0, 2'b11, 5'd12, 5'd13, 0, 2'b11, 0, 0, 2, 0);
        for (int i = 0; i < 7; i++) send(wr);
        send(mk(0, 2'b01, COND_NEVER, COND_NEVER, 2'b00, 2'b00, 0, 0, 2'b01, 5'd0, 5'd14, 0, 2'b01, 0, 0, 1, 0));
        drain();
        @(posedge clk); #1;
        chk("retired_max", o_retired, 15);
        send(wr);
        drain();
        @(posedge clk); #1;
        chk("retired_wrap", o_retired, 1);
        chk("retired_model", o_retired, exp_ret);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
